// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART timing constants and increment helper
package uart_pkg;

  // Phase accumulator width used by the bit-clock generators.
  localparam int ACC_W_DEFAULT = 24;

  // Oversampling ticks per UART bit.
  localparam int OVERSAMPLE_DEFAULT = 16;

  // Accumulator increment for a given clock, baud and oversample, rounded
  // to nearest: inc = round(baud * oversample * 2^acc_w / clk_hz).
  function automatic longint unsigned calc_inc(
    input longint unsigned clk_hz,
    input longint unsigned baud,
    input longint unsigned oversample,
    input int              acc_w
  );
    longint unsigned num;
    num = (baud * oversample) << acc_w;
    return (num + (clk_hz / 2)) / clk_hz;
  endfunction

endpackage

// File: rtl/phase_accumulator.sv
// rtl/phase_accumulator.sv - fractional phase accumulator with restart and enable muxing
module phase_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [ACC_W-1:0] inc,
  output logic             carry
);

  // Restart re-aligns to half phase so the first tick lands mid-period.
  localparam logic [ACC_W-1:0] HALF_PHASE = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  // One extra bit on the adder captures the overflow that becomes a tick.
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, inc};
    carry = enable && !restart && sum[ACC_W];
  end

  // Restart beats enable; with enable low the phase simply holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (restart) begin
      acc <= HALF_PHASE;
    end else if (enable) begin
      acc <= sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/baud_tick_generator.sv
// rtl/baud_tick_generator.sv - programmable oversample/bit tick and baud clock generator
module baud_tick_generator
  import uart_pkg::*;
#(
  parameter int          ACC_W       = ACC_W_DEFAULT,
  parameter int          OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int unsigned DEFAULT_INC = 103079
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic             inc_load,
  input  logic [ACC_W-1:0] inc_value,
  output logic [ACC_W-1:0] inc,
  output logic             os_tick,
  output logic             bit_tick,
  output logic             baud_clk
);

  localparam int               CNT_W   = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2);
  localparam logic [ACC_W-1:0] INC_RST = ACC_W'(DEFAULT_INC);

  logic             carry;
  logic [CNT_W-1:0] os_cnt;
  logic [CNT_W-1:0] os_cnt_nxt;
  logic             last_os;

  phase_accumulator #(
    .ACC_W (ACC_W)
  ) u_phase_accumulator (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .restart (restart),
    .inc     (inc),
    .carry   (carry)
  );

  // Increment register; the accumulation in the load cycle still sees the old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inc <= INC_RST;
    end else if (inc_load) begin
      inc <= inc_value;
    end
  end

  // Oversample position within the bit, advanced only on an overflow.
  always_comb begin
    last_os    = (os_cnt == CNT_MAX);
    os_cnt_nxt = os_cnt;
    if (carry) begin
      os_cnt_nxt = last_os ? '0 : os_cnt + 1'b1;
    end
  end

  // Registered ticks and square wave; restart clears, disable freezes with ticks low.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      baud_clk <= 1'b0;
    end else if (restart) begin
      os_cnt   <= '0;
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
      baud_clk <= 1'b0;
    end else if (enable) begin
      os_cnt   <= os_cnt_nxt;
      os_tick  <= carry;
      bit_tick <= carry && last_os;
      baud_clk <= (os_cnt_nxt >= CNT_HALF);
    end else begin
      os_tick  <= 1'b0;
      bit_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_tick_generator.sv
// tb/tb_baud_tick_generator.sv - scoreboard bench for baud_tick_generator
module tb_baud_tick_generator;
  import uart_pkg::*;

  localparam int     ACC_W = 24;
  localparam int     OS    = 16;
  localparam longint MOD   = 64'd1 << ACC_W;
  localparam longint HALF  = 64'd1 << (ACC_W - 1);
  localparam longint DEF   = 103079;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             restart = 1'b0;
  logic             inc_load = 1'b0;
  logic [ACC_W-1:0] inc_value = '0;
  logic [ACC_W-1:0] inc;
  logic             os_tick;
  logic             bit_tick;
  logic             baud_clk;

  baud_tick_generator #(
    .ACC_W       (ACC_W),
    .OVERSAMPLE  (OS),
    .DEFAULT_INC (103079)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .restart   (restart),
    .inc_load  (inc_load),
    .inc_value (inc_value),
    .inc       (inc),
    .os_tick   (os_tick),
    .bit_tick  (bit_tick),
    .baud_clk  (baud_clk)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit     os;
    bit     bt;
    bit     bc;
    longint inc;
  } exp_t;

  exp_t   q[$];
  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  int     os_times[$];
  int     bit_times[$];
  int     baud_hi = 0;

  // Reference: phase as a plain integer fraction of one oversample period,
  // tick count modulo OS, baud high in the upper half of the bit.
  longint m_phase;
  longint m_inc;
  int     m_cnt;
  bit     m_baud;
  longint m_sum;
  exp_t   m_e;
  exp_t   got;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d (cycle %0d)", name, act, lo, hi, cyc);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_phase = 0;
      m_inc   = DEF;
      m_cnt   = 0;
      m_baud  = 0;
    end else begin
      m_e.os = 0;
      m_e.bt = 0;
      if (restart) begin
        m_phase = HALF;
        m_cnt   = 0;
        m_baud  = 0;
      end else if (enable) begin
        m_sum = m_phase + m_inc;
        if (m_sum >= MOD) begin
          m_e.os = 1;
          m_e.bt = (m_cnt == OS - 1);
          m_cnt  = (m_cnt + 1) % OS;
          m_sum  = m_sum - MOD;
        end
        m_phase = m_sum;
        m_baud  = (m_cnt >= OS / 2);
      end
      if (inc_load) m_inc = longint'(inc_value);
      m_e.bc  = m_baud;
      m_e.inc = m_inc;
      q.push_back(m_e);
    end
  end

  always @(negedge clock) begin
    if (!reset || q.size() == 0) begin
      q.delete();
      chk("reset_os_tick", os_tick, 0);
      chk("reset_bit_tick", bit_tick, 0);
      chk("reset_baud_clk", baud_clk, 0);
      chk("reset_inc", inc, DEF);
    end else begin
      got = q.pop_front();
      chk("os_tick", os_tick, got.os);
      chk("bit_tick", bit_tick, got.bt);
      chk("baud_clk", baud_clk, got.bc);
      chk("inc", inc, got.inc);
      if (bit_tick) chk("bit_without_os", os_tick, 1);
      if (os_tick) os_times.push_back(cyc);
      if (bit_tick) bit_times.push_back(cyc);
      if (baud_clk) baud_hi++;
    end
  end

  int p;
  int iv;
  int r;

  initial begin
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
    reset  = 1'b1;
    enable = 1'b1;
    os_times.delete();
    repeat (1800) @(negedge clock);
    chk_range("default_tick_count", os_times.size(), 11, 20);
    if (os_times.size() >= 11) begin
      for (int i = 1; i <= 10; i++) begin
        iv = os_times[i] - os_times[i-1];
        chk_range("default_interval", iv, 162, 163);
      end
      chk_range("default_10_span", os_times[10] - os_times[0], 1623, 1632);
    end

    @(negedge clock);
    inc_load  = 1'b1;
    inc_value = 24'd1 << 22;
    restart   = 1'b1;
    @(posedge clock);
    #1;
    p        = cyc;
    inc_load = 1'b0;
    restart  = 1'b0;
    os_times.delete();
    bit_times.delete();
    repeat (200) @(negedge clock);
    chk_range("exact_os_count", os_times.size(), 40, 60);
    chk_range("exact_bit_count", bit_times.size(), 3, 4);
    if (os_times.size() >= 40 && bit_times.size() >= 3) begin
      chk("restart_first_os", os_times[0], p + 2);
      chk("restart_first_bit", bit_times[0], p + 62);
      for (int i = 1; i < 40; i++) chk("exact_os_interval", os_times[i] - os_times[i-1], 4);
      for (int i = 1; i < 3; i++) chk("exact_bit_interval", bit_times[i] - bit_times[i-1], 64);
    end
    baud_hi = 0;
    repeat (128) @(negedge clock);
    chk("baud_duty_128", baud_hi, 64);

    @(negedge clock);
    inc_load  = 1'b1;
    inc_value = 24'd1 << 21;
    @(posedge clock);
    #1;
    inc_load = 1'b0;
    os_times.delete();
    repeat (100) @(negedge clock);
    chk_range("live_os_count", os_times.size(), 11, 14);
    if (os_times.size() >= 11) begin
      for (int i = 2; i < 11; i++) chk("live_os_interval", os_times[i] - os_times[i-1], 8);
    end

    @(negedge clock);
    enable = 1'b0;
    @(posedge clock);
    #1;
    os_times.delete();
    repeat (9) @(posedge clock);
    #1;
    chk("disabled_ticks", os_times.size(), 0);
    @(negedge clock);
    enable = 1'b1;
    repeat (50) @(negedge clock);

    inc_load  = 1'b1;
    inc_value = '0;
    @(posedge clock);
    #1;
    inc_load = 1'b0;
    @(posedge clock);
    #1;
    os_times.delete();
    repeat (1000) @(negedge clock);
    chk("zero_inc_ticks", os_times.size(), 0);

    inc_load  = 1'b1;
    inc_value = 24'd1 << 22;
    @(negedge clock);
    inc_load = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clock);
      enable   = ($urandom % 8) != 0;
      restart  = ($urandom % 300) == 0;
      inc_load = ($urandom % 200) == 0;
      r = $urandom % 3;
      if (r == 0) inc_value = 24'd1 << (18 + ($urandom % 5));
      else if (r == 1) inc_value = ACC_W'($urandom % (1 << 23));
      else inc_value = ACC_W'((1 << 22) + ($urandom % (1 << 20)));
    end
    @(negedge clock);
    enable    = 1'b1;
    restart   = 1'b0;
    inc_load  = 1'b1;
    inc_value = 24'd1 << 22;
    @(negedge clock);
    inc_load = 1'b0;
    repeat (37) @(negedge clock);

    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_os_tick", os_tick, 0);
    chk("async_reset_bit_tick", bit_tick, 0);
    chk("async_reset_baud_clk", baud_clk, 0);
    chk("async_reset_inc", inc, DEF);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (400) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/baud_tick_generator.md
# baud_tick_generator

Parametrised successor to the fixed-divide UART bit clock. Uses a fractional phase accumulator to produce an oversampling tick (`os_tick`), a bit-rate tick (`bit_tick`) and a square-wave bit clock (`baud_clk`) from the system clock. The increment is runtime-programmable, so baud rate changes need no re-synthesis. A `restart` input phase-aligns the generator to a detected start bit. It sits between the clock domain and the UART TX/RX engines.

## Interface
- `ACC_W`, default 24: phase accumulator width in bits.
- `OVERSAMPLE`, default 16: oversampling ticks per bit. Even, range 2–64.
- `DEFAULT_INC`, default 103079: increment after reset. Gives 9600 baud × 16 at a 25 MHz clock.
- `clock  input  1`: system clock. All logic is on the rising edge.
- `reset  input  1`: asynchronous, active-low reset.
- `enable  input  1`: accumulate when high. When low, hold all state and drive ticks to 0.
- `restart  input  1`: synchronous phase re-align pulse.
- `inc_load  input  1`: load `inc_value` into the increment register.
- `inc_value  input  ACC_W`: new increment.
- `inc  output  ACC_W`: current increment register, for readback.
- `os_tick  output  1`: one-cycle oversample tick.
- `bit_tick  output  1`: one-cycle bit tick.
- `baud_clk  output  1`: bit-rate square wave.

## Operation
- **Reset values** (`reset`=0, asynchronous): `acc`=0, `inc`=`DEFAULT_INC`, `os_cnt`=0, `os_tick`=0, `bit_tick`=0, `baud_clk`=0.
- **Accumulator step** (`enable`=1, `restart`=0):
  - `{carry, acc} <= acc + inc`, computed at ACC_W+1 bits. The carry is the overflow; there is no saturation.
- **Tick generation:**
  - `os_tick <= carry`.
  - On carry, `os_cnt` increments modulo `OVERSAMPLE`.
  - `bit_tick <= carry && (os_cnt == OVERSAMPLE-1)`.
- **`baud_clk`:** registered. Equals 1 when the post-update `os_cnt` is ≥ `OVERSAMPLE`/2, else 0. Duty cycle is 50% in oversample units.
- **Tick rate:** `os_tick` average rate is `f_clock × inc / 2^ACC_W`. `inc` must be less than 2^(ACC_W−1) to guarantee ticks are never adjacent; this is software's responsibility and is not checked.
- **`inc` = 0:** no ticks; outputs hold.
- **`enable`=0:** `acc`, `os_cnt` and `baud_clk` hold. `os_tick` and `bit_tick` are 0.
- **`restart`=1** (highest priority, independent of `enable`):
  - `acc` <= 2^(ACC_W−1) (half phase).
  - `os_cnt` <= 0.
  - `baud_clk` <= 0.
  - `os_tick` and `bit_tick` <= 0 in that cycle.
  - Effect: the first `os_tick` after restart arrives half an oversample period later, centring RX sampling.
- **`inc_load`=1:** `inc <= inc_value`. Independent of `enable` and `restart`. Both apply when asserted together.
  - The new value is used from the next accumulation; the accumulation in the load cycle uses the old `inc`.
  - `acc` is not cleared on load, so there is no phase jump.

## Timing
- Latency from accumulator overflow to `os_tick`/`bit_tick`: 1 cycle (registered outputs, no combinational path from inputs).
- `restart` asserted in cycle N:
  - Ticks are 0 in cycle N+1.
  - With `inc` = 2^k, the first `os_tick` is in cycle N+1+2^(ACC_W−1−k).
- `inc_load` in cycle N: `inc` output updates in cycle N+1, and the accumulation in N+1 uses the new value.
- `bit_tick` is always coincident with an `os_tick`, never alone.
- Reset deasserting mid-operation: the first accumulation happens on the first rising edge with `reset`=1.

## Structure
- Shared package `uart_pkg`:
  - `ACC_W_DEFAULT` and `OVERSAMPLE_DEFAULT`.
  - A constant function `calc_inc(clk_hz, baud, oversample, acc_w)`, rounding to nearest.
- One natural sub-module, `phase_accumulator`:
  - Holds the ACC_W register, adder, carry out and the restart/enable muxing.
  - The top level holds the increment register, `os_cnt`, and tick/`baud_clk` registers.

## Test plan
- **Reset and default rate:** hold `reset`=0, then release, `enable`=1 → all outputs 0 at release; with `DEFAULT_INC`=103079, `os_tick` intervals are 162 or 163 cycles, and the average over 10 ticks is within 0.5 cycle of 162.76.
- **Exact divide:** `inc_load` with 2^22 (ACC_W=24) → `os_tick` every 4 cycles, `bit_tick` every 64 cycles; `baud_clk` is high for 32 cycles and low for 32.
- **Restart alignment:** `inc`=2^22, `restart` pulse in cycle N → no ticks in N+1; first `os_tick` in N+3 (half phase = 2 steps); `os_cnt` restarts so `bit_tick` is at N+3+60.
- **Live increment change:** switch `inc` from 2^22 to 2^21 between ticks → no lost or extra `os_tick`; the interval changes from 4 to 8 cycles starting with the accumulation after the load.
- **Enable gating / zero increment:** drop `enable` for 10 cycles mid-bit → no ticks, and `baud_clk` and phase resume unchanged; load `inc`=0 → no ticks for 1000 cycles.
- **Simultaneous restart + inc_load + reset assert mid-bit:** restart and load both applied in the same cycle; asynchronous reset assertion clears outputs with no clock edge.
